// File: rtl/csr_mgr_mmio_if.sv
// MMIO request/response bus plus the application CSR bundle for csr_mgr_mmio.
// master = host shim / application side, slave = csr_mgr_mmio.
interface csr_mgr_mmio_if #(
  parameter int NUM_APP_CSRS   = 4,
  parameter int MMIO_ADDR_BITS = 16
);
  logic                        mmio_wr_valid;
  logic [MMIO_ADDR_BITS-1:0]   mmio_wr_addr;
  logic [63:0]                 mmio_wr_data;
  logic                        mmio_rd_valid;
  logic [MMIO_ADDR_BITS-1:0]   mmio_rd_addr;
  logic [8:0]                  mmio_rd_tid;
  logic                        mmio_rsp_valid;
  logic [8:0]                  mmio_rsp_tid;
  logic [63:0]                 mmio_rsp_data;
  logic [127:0]                afu_id;
  logic [64*NUM_APP_CSRS-1:0]  app_rd_data;
  logic [NUM_APP_CSRS-1:0]     app_wr_en;
  logic [63:0]                 app_wr_data;

  modport master (
    output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    output afu_id, app_rd_data,
    input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    input  app_wr_en, app_wr_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    input  afu_id, app_rd_data,
    output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    output app_wr_en, app_wr_data
  );
endinterface

// File: rtl/csr_mgr_mmio.sv
// MMIO front end of the application CSR manager: write strobes and a 2-stage read pipeline.
// Optional free-running cycle counter at byte 0x38 enabled by defining CSR_MGR_CYCLE_CNT_EN.
module csr_mgr_mmio #(
  parameter int NUM_APP_CSRS   = 4,
  parameter int MMIO_ADDR_BITS = 16,
  parameter int CNT_BITS       = 40
) (
  input  logic          clk,
  input  logic          reset_n,
  csr_mgr_mmio_if.slave bus
);
  localparam int AW = MMIO_ADDR_BITS;
  localparam logic [63:0]   DFH_VAL = 64'h1000_0100_0000_0000;
  localparam logic [AW-1:0] A_DFH   = AW'(0);
  localparam logic [AW-1:0] A_ID_L  = AW'(2);
  localparam logic [AW-1:0] A_ID_H  = AW'(4);
  localparam logic [AW-1:0] A_APP0  = AW'(16);
  localparam logic [AW-1:0] A_NUM   = AW'(NUM_APP_CSRS);

  if (NUM_APP_CSRS < 1 || NUM_APP_CSRS > 16) begin : g_bad_num
    $error("NUM_APP_CSRS must be 1..16");
  end
  if (CNT_BITS < 1 || CNT_BITS > 64) begin : g_bad_cnt
    $error("CNT_BITS must be 1..64");
  end

  logic                    r_s1_valid;
  logic [AW-1:0]           r_s1_addr;
  logic [8:0]              r_s1_tid;
  logic                    r_rsp_valid;
  logic [8:0]              r_rsp_tid;
  logic [63:0]             r_rsp_data;
  logic [NUM_APP_CSRS-1:0] r_wr_en;
  logic [63:0]             r_wr_data;

  logic [AW-1:0]           w_wr_off;
  logic [AW-1:0]           w_rd_off;
  logic                    w_wr_app_hit;
  logic                    w_rd_app_hit;
  logic [NUM_APP_CSRS-1:0] w_wr_en;
  logic [63:0]             w_rd_data;

  // Slot index is compared at full address width so high addresses never alias onto a slot.
  assign w_wr_off     = bus.mmio_wr_addr - A_APP0;
  assign w_rd_off     = r_s1_addr - A_APP0;
  assign w_wr_app_hit = !bus.mmio_wr_addr[0] && (bus.mmio_wr_addr >= A_APP0) && ((w_wr_off >> 1) < A_NUM);
  assign w_rd_app_hit = !r_s1_addr[0] && (r_s1_addr >= A_APP0) && ((w_rd_off >> 1) < A_NUM);

`ifdef CSR_MGR_CYCLE_CNT_EN
  localparam logic [AW-1:0] A_CNT = AW'(14);
  logic [CNT_BITS-1:0] r_cnt;
  logic                w_cnt_clr;

  assign w_cnt_clr = bus.mmio_wr_valid && (bus.mmio_wr_addr == A_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end
`endif

  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < NUM_APP_CSRS; i++) begin
      if (bus.mmio_wr_valid && w_wr_app_hit && ((w_wr_off >> 1) == AW'(i))) begin
        w_wr_en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (!r_s1_addr[0]) begin
      if (r_s1_addr == A_DFH) begin
        w_rd_data = DFH_VAL;
      end else if (r_s1_addr == A_ID_L) begin
        w_rd_data = bus.afu_id[63:0];
      end else if (r_s1_addr == A_ID_H) begin
        w_rd_data = bus.afu_id[127:64];
`ifdef CSR_MGR_CYCLE_CNT_EN
      end else if (r_s1_addr == A_CNT) begin
        w_rd_data = 64'(r_cnt);
`endif
      end else if (w_rd_app_hit) begin
        for (int i = 0; i < NUM_APP_CSRS; i++) begin
          if ((w_rd_off >> 1) == AW'(i)) begin
            w_rd_data = bus.app_rd_data[64*i +: 64];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_tid    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
      r_wr_en     <= '0;
      r_wr_data   <= '0;
    end else begin
      r_s1_valid  <= bus.mmio_rd_valid;
      if (bus.mmio_rd_valid) begin
        r_s1_addr <= bus.mmio_rd_addr;
        r_s1_tid  <= bus.mmio_rd_tid;
      end
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_tid  <= r_s1_tid;
        r_rsp_data <= w_rd_data;
      end
      r_wr_en <= w_wr_en;
      if (|w_wr_en) begin
        r_wr_data <= bus.mmio_wr_data;
      end
    end
  end

  assign bus.mmio_rsp_valid = r_rsp_valid;
  assign bus.mmio_rsp_tid   = r_rsp_tid;
  assign bus.mmio_rsp_data  = r_rsp_data;
  assign bus.app_wr_en      = r_wr_en;
  assign bus.app_wr_data    = r_wr_data;
endmodule

// File: tb/tb_csr_mgr_mmio.sv
// Self-checking bench for csr_mgr_mmio: vector tables, directed corner sequences, randomized model check.
module tb_csr_mgr_mmio;
  localparam int NUM = 4;
  localparam int AW  = 16;
  localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [8:0]    tid;
    logic [63:0]   exp;
  } rd_vec_t;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [63:0]    data;
    logic [NUM-1:0] exp_en;
  } wr_vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  csr_mgr_mmio_if #(.NUM_APP_CSRS(NUM), .MMIO_ADDR_BITS(AW)) bus ();

  csr_mgr_mmio #(.NUM_APP_CSRS(NUM), .MMIO_ADDR_BITS(AW), .CNT_BITS(40)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [127:0] afu_c;
  logic [63:0]  app_c [NUM];
  logic [63:0]  exp_wdata;
  rd_vec_t      rv [$];
  wr_vec_t      wv [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_wr_addr  = '0;
    bus.mmio_wr_data  = '0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_rd_addr  = '0;
    bus.mmio_rd_tid   = '0;
  endtask

  task automatic drive_app();
    bus.afu_id = afu_c;
    for (int i = 0; i < NUM; i++) bus.app_rd_data[64*i +: 64] = app_c[i];
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [8:0] tid);
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_rd_addr  = addr;
    bus.mmio_rd_tid   = tid;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [63:0] data);
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_wr_addr  = addr;
    bus.mmio_wr_data  = data;
  endtask

  // Reference decode from the byte-offset register map.
  function automatic logic [63:0] ref_read(input logic [AW-1:0] addr, input logic [127:0] afu,
                                           input logic [64*NUM-1:0] app);
    int boff;
    boff = int'(addr) * 4;
    if (addr % 2 != 0) return 64'd0;
    if (boff == 0)  return DFH;
    if (boff == 8)  return afu[63:0];
    if (boff == 16) return afu[127:64];
    if (boff >= 'h40 && (boff - 'h40) / 8 < NUM) return app[64*((boff - 'h40) / 8) +: 64];
    return 64'd0;
  endfunction

  function automatic logic [NUM-1:0] ref_wen(input logic [AW-1:0] addr);
    int boff;
    boff = int'(addr) * 4;
    if (addr % 2 != 0) return '0;
    if (boff >= 'h40 && (boff - 'h40) / 8 < NUM) return NUM'(1) << ((boff - 'h40) / 8);
    return '0;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    if ($urandom_range(0, 9) < 8) a = AW'($urandom_range(0, 31));
    else a = AW'($urandom);
    return a;
  endfunction

  initial begin
    logic          p_valid;
    logic [AW-1:0] p_addr;
    logic [8:0]    p_tid;
    logic          c_rv, c_wv;
    logic [AW-1:0] c_raddr, c_waddr;
    logic [8:0]    c_tid;
    logic [63:0]   c_wdata;
    logic [NUM-1:0] e_en;
    logic [64*NUM-1:0] app_flat;

    afu_c    = 128'hA5A5_1122_3344_5566_7788_99AA_BBCC_DD5A;
    app_c[0] = 64'h0123_4567_89AB_CDEF;
    app_c[1] = 64'hFEDC_BA98_7654_3210;
    app_c[2] = 64'h0000_0000_0000_1234;
    app_c[3] = 64'h5555_AAAA_0F0F_F0F0;
    exp_wdata = '0;
    idle();
    drive_app();

    rv.push_back('{16'h0000, 9'd1,  DFH});
    rv.push_back('{16'h0002, 9'd2,  64'h7788_99AA_BBCC_DD5A});
    rv.push_back('{16'h0004, 9'd3,  64'hA5A5_1122_3344_5566});
    rv.push_back('{16'h0006, 9'd4,  64'd0});
    rv.push_back('{16'h0008, 9'd5,  64'd0});
    rv.push_back('{16'h0001, 9'd6,  64'd0});
    rv.push_back('{16'h0003, 9'd7,  64'd0});
    rv.push_back('{16'h0010, 9'd8,  64'h0123_4567_89AB_CDEF});
    rv.push_back('{16'h0012, 9'd9,  64'hFEDC_BA98_7654_3210});
    rv.push_back('{16'h0014, 9'd10, 64'h0000_0000_0000_1234});
    rv.push_back('{16'h0016, 9'd11, 64'h5555_AAAA_0F0F_F0F0});
    rv.push_back('{16'h0018, 9'd12, 64'd0});
    rv.push_back('{16'h0011, 9'd13, 64'd0});
    rv.push_back('{16'h8014, 9'd14, 64'd0});
    rv.push_back('{16'hFFFF, 9'd15, 64'd0});
    rv.push_back('{16'h000A, 9'd16, 64'd0});
`ifndef CSR_MGR_CYCLE_CNT_EN
    rv.push_back('{16'h000E, 9'd17, 64'd0});
`endif

    wv.push_back('{16'h0012, 64'h0000_0000_DEAD_BEEF, 4'b0010});
    wv.push_back('{16'h0018, 64'h1111_1111_1111_1111, 4'b0000});
    wv.push_back('{16'h0010, 64'h2222_0000_0000_2222, 4'b0001});
    wv.push_back('{16'h0011, 64'h3333_3333_3333_3333, 4'b0000});
    wv.push_back('{16'h0000, 64'h4444_4444_4444_4444, 4'b0000});
    wv.push_back('{16'h0002, 64'h5555_5555_5555_5555, 4'b0000});
    wv.push_back('{16'h0004, 64'h6666_6666_6666_6666, 4'b0000});
    wv.push_back('{16'h0006, 64'h7777_7777_7777_7777, 4'b0000});
    wv.push_back('{16'h000E, 64'h8888_8888_8888_8888, 4'b0000});
    wv.push_back('{16'h8012, 64'h9999_9999_9999_9999, 4'b0000});
    wv.push_back('{16'h0016, 64'hAAAA_0000_0000_AAAA, 4'b1000});
    wv.push_back('{16'h0014, 64'hBBBB_0000_0000_BBBB, 4'b0100});

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 128'(bus.mmio_rsp_valid), 128'd0);
    chk("reset_rsp_tid",   128'(bus.mmio_rsp_tid),   128'd0);
    chk("reset_rsp_data",  128'(bus.mmio_rsp_data),  128'd0);
    chk("reset_wr_en",     128'(bus.app_wr_en),      128'd0);
    chk("reset_wr_data",   128'(bus.app_wr_data),    128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // DFH read latency: nothing at T+1, response at T+2 only
    rd(16'h0000, 9'd5);
    @(negedge clk);
    idle();
    chk("dfh_no_rsp_t1", 128'(bus.mmio_rsp_valid), 128'd0);
    @(negedge clk);
    chk("dfh_rsp_valid", 128'(bus.mmio_rsp_valid), 128'd1);
    chk("dfh_rsp_tid",   128'(bus.mmio_rsp_tid),   128'd5);
    chk("dfh_rsp_data",  128'(bus.mmio_rsp_data),  128'(DFH));
    @(negedge clk);
    chk("dfh_rsp_gone",  128'(bus.mmio_rsp_valid), 128'd0);

    foreach (wv[i]) begin
      wr(wv[i].addr, wv[i].data);
      @(negedge clk);
      idle();
      chk($sformatf("wr%0d_en", i), 128'(bus.app_wr_en), 128'(wv[i].exp_en));
      if (wv[i].exp_en != '0) begin
        exp_wdata = wv[i].data;
        chk($sformatf("wr%0d_data", i), 128'(bus.app_wr_data), 128'(exp_wdata));
      end
      @(negedge clk);
      chk($sformatf("wr%0d_en_off", i), 128'(bus.app_wr_en), 128'd0);
    end
    repeat (3) @(negedge clk);
    chk("wr_data_hold", 128'(bus.app_wr_data), 128'(exp_wdata));

    // Same-cycle read and write of slot 2: read sees app value, write strobes independently
    rd(16'h0014, 9'd7);
    wr(16'h0014, 64'h0000_0000_0000_CAFE);
    @(negedge clk);
    idle();
    exp_wdata = 64'h0000_0000_0000_CAFE;
    chk("rw_wr_en",   128'(bus.app_wr_en),   128'b0100);
    chk("rw_wr_data", 128'(bus.app_wr_data), 128'(exp_wdata));
    chk("rw_no_rsp",  128'(bus.mmio_rsp_valid), 128'd0);
    @(negedge clk);
    chk("rw_rsp_valid", 128'(bus.mmio_rsp_valid), 128'd1);
    chk("rw_rsp_tid",   128'(bus.mmio_rsp_tid),   128'd7);
    chk("rw_rsp_data",  128'(bus.mmio_rsp_data),  128'h1234);
    chk("rw_wr_en_off", 128'(bus.app_wr_en),      128'd0);
    @(negedge clk);

    // Back-to-back read stream: response for vector i-1 visible after iteration i
    for (int i = 0; i <= rv.size(); i++) begin
      if (i < rv.size()) rd(rv[i].addr, rv[i].tid);
      else idle();
      @(negedge clk);
      if (i == 0) begin
        chk("stream_first_idle", 128'(bus.mmio_rsp_valid), 128'd0);
      end else begin
        chk($sformatf("stream%0d_valid", i-1), 128'(bus.mmio_rsp_valid), 128'd1);
        chk($sformatf("stream%0d_tid", i-1),   128'(bus.mmio_rsp_tid),   128'(rv[i-1].tid));
        chk($sformatf("stream%0d_data", i-1),  128'(bus.mmio_rsp_data),  128'(rv[i-1].exp));
      end
    end
    idle();
    @(negedge clk);
    chk("stream_end_idle", 128'(bus.mmio_rsp_valid), 128'd0);

`ifdef CSR_MGR_CYCLE_CNT_EN
    wr(16'h000E, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    idle();
    chk("cnt_clr_no_strobe", 128'(bus.app_wr_en), 128'd0);
    rd(16'h000E, 9'd3);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("cnt_rsp_valid", 128'(bus.mmio_rsp_valid), 128'd1);
    chk("cnt_after_clr", 128'(bus.mmio_rsp_data),  128'd1);
    @(negedge clk);
`endif

    // Reset mid-operation: read in stage 1 and a write not yet strobed are both discarded
    rd(16'h0000, 9'd9);
    @(negedge clk);
    idle();
    wr(16'h0012, 64'h0BAD_0BAD_0BAD_0BAD);
    #2 reset_n = 1'b0;
    #1 idle();
    @(negedge clk);
    exp_wdata = '0;
    chk("rst_mid_rsp_valid", 128'(bus.mmio_rsp_valid), 128'd0);
    chk("rst_mid_wr_en",     128'(bus.app_wr_en),      128'd0);
    chk("rst_mid_wr_data",   128'(bus.app_wr_data),    128'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d_rsp", i), 128'(bus.mmio_rsp_valid), 128'd0);
      chk($sformatf("rst_after%0d_en", i),  128'(bus.app_wr_en),      128'd0);
    end

    // Randomized traffic against the map model; app/afu values change every cycle
    p_valid = 1'b0;
    p_addr  = '0;
    p_tid   = '0;
    for (int c = 0; c < 400; c++) begin
      c_rv    = ($urandom_range(0, 2) != 0);
      c_raddr = pick_addr();
`ifdef CSR_MGR_CYCLE_CNT_EN
      if (c_raddr == AW'(14)) c_raddr = AW'(15);
`endif
      c_tid   = 9'($urandom_range(0, 511));
      c_wv    = ($urandom_range(0, 1) != 0);
      c_waddr = pick_addr();
      c_wdata = {$urandom, $urandom};
      afu_c   = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NUM; i++) app_c[i] = {$urandom, $urandom};
      drive_app();
      bus.mmio_rd_valid = c_rv;
      bus.mmio_rd_addr  = c_raddr;
      bus.mmio_rd_tid   = c_tid;
      bus.mmio_wr_valid = c_wv;
      bus.mmio_wr_addr  = c_waddr;
      bus.mmio_wr_data  = c_wdata;
      @(negedge clk);
      for (int i = 0; i < NUM; i++) app_flat[64*i +: 64] = app_c[i];
      chk("rnd_rsp_valid", 128'(bus.mmio_rsp_valid), 128'(p_valid));
      if (p_valid) begin
        chk("rnd_rsp_tid",  128'(bus.mmio_rsp_tid),  128'(p_tid));
        chk("rnd_rsp_data", 128'(bus.mmio_rsp_data), 128'(ref_read(p_addr, afu_c, app_flat)));
      end
      e_en = c_wv ? ref_wen(c_waddr) : '0;
      chk("rnd_wr_en", 128'(bus.app_wr_en), 128'(e_en));
      if (e_en != '0) begin
        exp_wdata = c_wdata;
        chk("rnd_wr_data", 128'(bus.app_wr_data), 128'(exp_wdata));
      end
      p_valid = c_rv;
      p_addr  = c_raddr;
      p_tid   = c_tid;
    end
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
